seq_detect_ctrl: RTL
====================

Name: seq_detect_ctrl

Overview:
Controller and scheduler for a programmable serial pattern detector of the Mealy family used in the sequence-detection guides. It latches a pattern and a frame length on a start handshake, then runs detection over a gated serial stream with overlap allowed. It counts matches, records the first match position, and signals completion. It lets a single testbench or upstream block reuse one detector for any 4-bit pattern instead of keeping one hard-coded FSM per sequence.

Parameters:
PW, 4, pattern width in bits (>=2)
CW, 8, match counter width
LW, 8, frame length / bit index width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (reset==0 clears the block)
start  input  1  begin a frame; sampled only in IDLE
abort  input  1  terminate the current frame early; sampled in ARM/RUN
pattern  input  PW  pattern to detect, MSB is the oldest bit; latched on start
frame_len  input  LW  number of valid bits in the frame; latched on start
x  input  1  serial data bit
x_valid  input  1  qualifies x; bits with x_valid==0 are ignored
y  output  1  Mealy match flag (combinational), high in the cycle the completing bit is presented
busy  output  1  high in ARM and RUN
done  output  1  one-cycle completion pulse
found  output  1  match_count != 0
match_count  output  CW  matches in the current/last frame, saturating
first_pos  output  LW  0-based bit index of the bit completing the first match; 0 if none

Behaviour:
- State encoding: IDLE=2'b00, ARM=2'b01, RUN=2'b11, DONE=2'b10.
- Reset (reset==0, asynchronous):
  - state=IDLE.
  - busy=0, done=0, match_count=0, first_pos=0.
  - Internal history, fill, bit counter, pattern register and length register all cleared.
  - y=0 because the state is not RUN.
- IDLE:
  - start=1 at a clk edge latches pattern and frame_len.
  - The same edge clears match_count, first_pos, history, fill count, bit_cnt and first-match flag.
  - Next state is ARM. If frame_len==0, next state is DONE instead.
  - start=0: hold; results from the last frame stay visible.
- ARM:
  - Lasts one cycle, busy=1, x ignored, then RUN.
  - abort=1 goes to DONE.
- RUN: busy=1. In each cycle with x_valid=1:
  - window = {hist[PW-2:0], x}.
  - match = (fill >= PW-1) && (window == pattern_reg); y = match, combinationally in the same cycle.
  - At the edge: hist <= window; fill increments, saturating at PW; bit_cnt increments.
  - On match, match_count increments, saturating at 2^CW-1 with no wrap.
  - On the first match of the frame, first_pos <= bit_cnt.
  - Overlapping matches are counted; no restart after a match.
  - If bit_cnt == len_reg-1, next state is DONE.
- RUN with x_valid=0: y=0 and all registers hold; x_valid gaps are transparent to the result.
- abort in RUN:
  - Next state is DONE.
  - If x_valid=1 in the same cycle, that bit is still processed, including a match and its count.
  - Abort coinciding with the final bit behaves like normal completion.
- DONE:
  - done=1 for exactly one cycle, busy=0, y=0, then IDLE.
  - start in DONE is ignored; it must be reasserted in IDLE.
- start outside IDLE is ignored. Inputs pattern and frame_len are only sampled at the start edge.
- Reset mid-frame aborts immediately without a done pulse. The first start after release behaves normally.
- Latency:
  - start to first accepted bit: 2 edges (IDLE→ARM→RUN).
  - Last accepted bit to done high: 1 cycle.

Test Plan:
1. Basic: pattern=4'b1000, frame_len=8, stream 1,0,0,0,1,0,0,0 with x_valid=1 -> y high on bits 3 and 7; match_count=2, first_pos=3, found=1; done pulses once on the cycle after bit 7, then IDLE.
2. Overlap: pattern=4'b1111, frame_len=6, six 1s -> y on bits 3,4,5; match_count=3, first_pos=3.
3. Gaps: repeat scenario 1 with x_valid=0 cycles inserted between every bit (x toggled randomly during gaps) -> identical match_count, first_pos and y timing relative to valid bits; y never high when x_valid=0.
4. Saturation: CW=2, pattern=4'b0000, frame_len=10, ten 0s -> 7 raw matches, match_count stays 3 with no wrap; y still pulses on bits 3..9.
5. Boundaries:
   - frame_len=0 -> ARM skipped; done pulses on the cycle after the IDLE state, match_count=0, first_pos=0.
   - abort on bit 2 of scenario 1 -> done next cycle, match_count=0, found=0.
6. Reset mid-RUN: reset=0 after 3 bits -> busy=0, match_count=0 immediately (async), no done pulse. After reset=1, scenario 1 runs and gives match_count=2.

Source files
------------

// File: rtl/seq_detect_ctrl_if.sv
// rtl/seq_detect_ctrl_if.sv - control, serial stream and result bundle for seq_detect_ctrl
interface seq_detect_ctrl_if #(
  parameter int PW = 4,
  parameter int CW = 8,
  parameter int LW = 8
);
  logic          start;
  logic          abort;
  logic [PW-1:0] pattern;
  logic [LW-1:0] frame_len;
  logic          x;
  logic          x_valid;
  logic          y;
  logic          busy;
  logic          done;
  logic          found;
  logic [CW-1:0] match_count;
  logic [LW-1:0] first_pos;

  modport master (
    output start, abort, pattern, frame_len, x, x_valid,
    input  y, busy, done, found, match_count, first_pos
  );

  modport slave (
    input  start, abort, pattern, frame_len, x, x_valid,
    output y, busy, done, found, match_count, first_pos
  );
endinterface

// File: rtl/seq_detect_ctrl.sv
// rtl/seq_detect_ctrl.sv - programmable overlapping Mealy pattern detector with frame scheduling
module seq_detect_ctrl #(
  parameter int PW = 4,
  parameter int CW = 8,
  parameter int LW = 8
) (
  input  logic              clk,
  input  logic              reset,
  seq_detect_ctrl_if.slave  bus
);
  localparam int FW = $clog2(PW + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ARM  = 2'b01,
    RUN  = 2'b11,
    DONE = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pat_q, pat_d;
  logic [LW-1:0] len_q, len_d;
  logic [PW-2:0] hist_q, hist_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [LW-1:0] bit_cnt_q, bit_cnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] first_pos_q, first_pos_d;
  logic          seen_q, seen_d;

  logic [PW-1:0] window;
  logic          accept;
  logic          match;
  logic          last_bit;

  // The match flag is Mealy: it depends on the bit presented this cycle, not only on state.
  always_comb begin
    window   = {hist_q, bus.x};
    accept   = (state_q == RUN) && bus.x_valid;
    match    = accept && (fill_q >= FW'(PW - 1)) && (window == pat_q);
    last_bit = (bit_cnt_q == (len_q - LW'(1)));
  end

  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    len_d       = len_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    bit_cnt_d   = bit_cnt_q;
    cnt_d       = cnt_q;
    first_pos_d = first_pos_q;
    seen_d      = seen_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          pat_d       = bus.pattern;
          len_d       = bus.frame_len;
          hist_d      = '0;
          fill_d      = '0;
          bit_cnt_d   = '0;
          cnt_d       = '0;
          first_pos_d = '0;
          seen_d      = 1'b0;
          state_d     = (bus.frame_len == '0) ? DONE : ARM;
        end
      end
      ARM: begin
        state_d = bus.abort ? DONE : RUN;
      end
      RUN: begin
        if (accept) begin
          hist_d    = window[PW-2:0];
          fill_d    = (fill_q == FW'(PW)) ? fill_q : fill_q + FW'(1);
          bit_cnt_d = bit_cnt_q + LW'(1);
          if (match) begin
            if (cnt_q != {CW{1'b1}}) begin
              cnt_d = cnt_q + CW'(1);
            end
            if (!seen_q) begin
              first_pos_d = bit_cnt_q;
              seen_d      = 1'b1;
            end
          end
          if (last_bit) begin
            state_d = DONE;
          end
        end
        // An abort still lets a bit presented in the same cycle be counted above.
        if (bus.abort) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pat_q       <= '0;
      len_q       <= '0;
      hist_q      <= '0;
      fill_q      <= '0;
      bit_cnt_q   <= '0;
      cnt_q       <= '0;
      first_pos_q <= '0;
      seen_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      len_q       <= len_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      bit_cnt_q   <= bit_cnt_d;
      cnt_q       <= cnt_d;
      first_pos_q <= first_pos_d;
      seen_q      <= seen_d;
    end
  end

  assign bus.y           = match;
  assign bus.busy        = (state_q == ARM) || (state_q == RUN);
  assign bus.done        = (state_q == DONE);
  assign bus.found       = (cnt_q != '0);
  assign bus.match_count = cnt_q;
  assign bus.first_pos   = first_pos_q;
endmodule
